// File: rtl/seg_scan_if.sv
// ----------------------------------------------------------------------------
// seg_scan_if
//   Bundles the host-facing and decoder-facing signals of the seg_scan
//   display scan controller.
//
//   Host -> scanner : wr_en, wr_addr[2:0], wr_data[2:0], rot_en, rot_dir
//   Scanner -> decoder: data1[2:0] (segment select), data2[2:0] (digit
//                       select), frame_tick (one-cycle pulse per frame wrap)
//
//   master : the host/environment side (drives writes and rotation control)
//   slave  : the seg_scan controller itself
// ----------------------------------------------------------------------------
interface seg_scan_if;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [2:0] wr_data;
  logic       rot_en;
  logic       rot_dir;
  logic [2:0] data1;
  logic [2:0] data2;
  logic       frame_tick;

  modport master (
    output wr_en, wr_addr, wr_data, rot_en, rot_dir,
    input  data1, data2, frame_tick
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rot_en, rot_dir,
    output data1, data2, frame_tick
  );
endinterface

// File: rtl/seg_scan.sv
// ----------------------------------------------------------------------------
// seg_scan
//   Display scan controller feeding a 7-segment decoder. Stores one 3-bit
//   position value per digit (six digits), cycles through the digits with a
//   DIV-cycle dwell each, and optionally rotates the stored values by one
//   place at every frame wrap (marquee effect).
//
//   Parameters
//     DIV        : clock cycles each digit is displayed (DIV >= 1)
//   Ports
//     clk        : clock, rising-edge active
//     rst_n      : asynchronous active-low reset
//     bus.wr_en/wr_addr/wr_data : host write into the value store
//                                 (addresses 6 and 7 are ignored)
//     bus.rot_en/rot_dir        : rotate at frame wrap (0 = left, 1 = right)
//     bus.data2  : registered digit select, always 0..5
//     bus.data1  : segment select, combinational read of val[data2]
//     bus.frame_tick : registered one-cycle pulse, high while data2 first
//                      shows 0 of a new frame
// ----------------------------------------------------------------------------
module seg_scan #(
  parameter int DIV = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  seg_scan_if.slave   bus
);

  localparam int            CW        = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(DIV - 1);
  localparam logic [2:0]    DIG_LAST  = 3'd5;
  localparam int            NUM_DIG   = 6;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    dig_q, dig_d;
  logic [2:0]    val_q [NUM_DIG];
  logic [2:0]    val_d [NUM_DIG];
  logic          frame_tick_q, frame_tick_d;

  logic          tick;
  logic          fb;
  logic [2:0]    rot_val [NUM_DIG];
  logic [2:0]    data1;

  // With DIV == 1 the counter is a single bit pinned at 0, so tick is
  // permanently high and the scan advances every cycle.
  assign tick = (cnt_q == CNT_LAST);
  assign fb   = tick && (dig_q == DIG_LAST);

  // NOTE: every signal written in an always_comb gets a default assignment
  // first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    cnt_d        = tick ? '0 : cnt_q + CW'(1);
    dig_d        = dig_q;
    frame_tick_d = fb;
    if (tick) begin
      dig_d = (dig_q == DIG_LAST) ? 3'd0 : dig_q + 3'd1;
    end
  end

  // Rotation is computed first; the host write then overrides the rotated
  // entry at its address, so a write in the frame-wrap cycle always lands
  // exactly where the host asked.
  always_comb begin
    for (int i = 0; i < NUM_DIG; i++) begin
      rot_val[i] = val_q[i];
    end
    if (fb && bus.rot_en) begin
      for (int i = 0; i < NUM_DIG; i++) begin
        if (!bus.rot_dir) begin
          rot_val[i] = val_q[(i + 1) % NUM_DIG];
        end else begin
          rot_val[i] = val_q[(i + NUM_DIG - 1) % NUM_DIG];
        end
      end
    end
  end

  // Addresses 6 and 7 never match any index, so they fall through as no-ops.
  always_comb begin
    for (int i = 0; i < NUM_DIG; i++) begin
      val_d[i] = rot_val[i];
      if (bus.wr_en && (bus.wr_addr == 3'(i))) begin
        val_d[i] = bus.wr_data;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // its pre-edge inputs regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      dig_q        <= '0;
      frame_tick_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      dig_q        <= dig_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  // NOTE: the value store is a small register file that must read back as
  // all-zero right after reset, so it is reset like any other flop rather
  // than being left to come up undefined.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_DIG; i++) begin
        val_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_DIG; i++) begin
        val_q[i] <= val_d[i];
      end
    end
  end

  // Explicit mux rather than an array index: dig_q is 3 bits but only 0..5
  // exist, and this keeps the read well defined without an out-of-range slot.
  always_comb begin
    data1 = '0;
    for (int i = 0; i < NUM_DIG; i++) begin
      if (dig_q == 3'(i)) begin
        data1 = val_q[i];
      end
    end
  end

  assign bus.data1      = data1;
  assign bus.data2      = dig_q;
  assign bus.frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg_scan.sv
// ----------------------------------------------------------------------------
// tb_seg_scan
//   Two seg_scan instances share clk/rst_n: one with DIV=4 (all directed
//   write/rotate stimulus) and one with DIV=1 (free-running scan). A model
//   derived from elapsed-cycle arithmetic predicts every output each cycle;
//   directed literal checks pin the model at key points.
// ----------------------------------------------------------------------------
module tb_seg_scan;

  typedef logic [2:0] store_t [6];

  localparam int DIV4   = 4;
  localparam int FRAME4 = 6 * DIV4;

  logic clk = 1'b0;
  logic rst_n;
  bit   started = 1'b0;

  int total = 0;
  int bad   = 0;

  seg_scan_if if4 ();
  seg_scan_if if1 ();

  seg_scan #(.DIV(DIV4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4));
  seg_scan #(.DIV(1))    dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Outputs follow from the number of edges n since reset: digit = (n/DIV)%6,
  // frame_tick at every multiple of 6*DIV; the store is a plain array.
  int     n4, n1;
  store_t mval;

  function automatic store_t next_store(input store_t s, input bit fb, input bit re,
                                        input bit rd, input bit we,
                                        input logic [2:0] a, input logic [2:0] d);
    store_t r;
    for (int i = 0; i < 6; i++) r[i] = s[i];
    if (fb && re) begin
      for (int i = 0; i < 6; i++) r[i] = rd ? s[(i + 5) % 6] : s[(i + 1) % 6];
    end
    if (we && a < 3'd6) r[a] = d;
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n4   <= 0;
      n1   <= 0;
      mval <= '{default: 3'd0};
    end else begin
      n4   <= n4 + 1;
      n1   <= n1 + 1;
      mval <= next_store(mval, ((n4 + 1) % FRAME4) == 0, if4.rot_en, if4.rot_dir,
                         if4.wr_en, if4.wr_addr, if4.wr_data);
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(posedge clk) begin
    #1;
    if (started) begin
      check("data2_div4", if4.data2, (n4 / DIV4) % 6);
      check("data1_div4", if4.data1, mval[(n4 / DIV4) % 6]);
      check("ftick_div4", if4.frame_tick, (n4 > 0 && n4 % FRAME4 == 0) ? 1 : 0);
      check("data2_div1", if1.data2, n1 % 6);
      check("data1_div1", if1.data1, 0);
      check("ftick_div1", if1.frame_tick, (n1 > 0 && n1 % 6 == 0) ? 1 : 0);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wr(input logic [2:0] a, input logic [2:0] d);
    @(negedge clk);
    if4.wr_en   = 1'b1;
    if4.wr_addr = a;
    if4.wr_data = d;
    @(negedge clk);
    if4.wr_en   = 1'b0;
  endtask

  task automatic load_ramp();
    for (int i = 0; i < 6; i++) wr(3'(i), 3'(i));
  endtask

  task automatic wait_dig(input logic [2:0] d);
    int k;
    for (k = 0; k < 100; k++) begin
      if (if4.data2 == d) break;
      @(posedge clk);
      #1;
    end
    if (k == 100) check("wait_dig_timeout", 1, 0);
  endtask

  task automatic wait_ft();
    int k;
    for (k = 0; k < 200; k++) begin
      @(posedge clk);
      #1;
      if (if4.frame_tick) break;
    end
    if (k == 200) check("wait_ft_timeout", 1, 0);
  endtask

  task automatic read_store(output store_t r);
    wait_dig(3'd0);
    for (int i = 0; i < 6; i++) begin
      r[i] = if4.data1;
      if (i < 5) begin
        repeat (DIV4) @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic check_store(input string name, input store_t got, input store_t exp);
    for (int i = 0; i < 6; i++) check($sformatf("%s[%0d]", name, i), got[i], exp[i]);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    store_t got;
    if4.wr_en = 0; if4.wr_addr = 0; if4.wr_data = 0; if4.rot_en = 0; if4.rot_dir = 0;
    if1.wr_en = 0; if1.wr_addr = 0; if1.wr_data = 0; if1.rot_en = 0; if1.rot_dir = 0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    check("rst_data2", if4.data2, 0);
    check("rst_data1", if4.data1, 0);
    check("rst_ftick", if4.frame_tick, 0);
    repeat (2) @(negedge clk);
    rst_n   = 1'b1;
    started = 1'b1;

    // Reset and scan: literal timing pins
    @(posedge clk); #1;
    check("lit_div1_edge1", if1.data2, 1);
    check("lit_div4_edge1", if4.data2, 0);
    repeat (3) @(posedge clk); #1;
    check("lit_div4_edge4", if4.data2, 1);
    repeat (2) @(posedge clk); #1;
    check("lit_div1_ft6", if1.frame_tick, 1);
    repeat (18) @(posedge clk); #1;
    check("lit_ft24", if4.frame_tick, 1);
    check("lit_dig24", if4.data2, 0);
    repeat (24) @(posedge clk); #1;
    check("lit_ft48", if4.frame_tick, 1);

    // Write and readback
    for (int i = 0; i < 6; i++) wr(3'(i), 3'((i + 2) % 8));
    read_store(got);
    check_store("wr_readback", got, '{3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7});

    // Invalid address
    wr(3'd6, 3'd7);
    wr(3'd7, 3'd1);
    read_store(got);
    check_store("bad_addr", got, '{3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7});

    // Left rotation, twice
    load_ramp();
    @(negedge clk);
    if4.rot_dir = 1'b0;
    if4.rot_en  = 1'b1;
    wait_ft();
    if4.rot_en = 1'b0;
    read_store(got);
    check_store("rot_left1", got, '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0});
    @(negedge clk);
    if4.rot_en = 1'b1;
    wait_ft();
    if4.rot_en = 1'b0;
    read_store(got);
    check_store("rot_left2", got, '{3'd2, 3'd3, 3'd4, 3'd5, 3'd0, 3'd1});

    // Right rotation
    load_ramp();
    @(negedge clk);
    if4.rot_dir = 1'b1;
    if4.rot_en  = 1'b1;
    wait_ft();
    if4.rot_en = 1'b0;
    read_store(got);
    check_store("rot_right", got, '{3'd5, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4});

    // Write and left rotation in the frame-wrap cycle
    load_ramp();
    if4.rot_dir = 1'b0;
    wait_ft();
    repeat (FRAME4) @(negedge clk);
    if4.rot_en  = 1'b1;
    if4.wr_en   = 1'b1;
    if4.wr_addr = 3'd0;
    if4.wr_data = 3'd7;
    @(negedge clk);
    if4.rot_en = 1'b0;
    if4.wr_en  = 1'b0;
    check("wrrot_ftick", if4.frame_tick, 1);
    read_store(got);
    check_store("wr_rot", got, '{3'd7, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0});

    // Mid-operation reset with a write in flight
    wait_dig(3'd3);
    @(negedge clk);
    if4.wr_en   = 1'b1;
    if4.wr_addr = 3'd3;
    if4.wr_data = 3'd6;
    rst_n       = 1'b0;
    #1;
    check("midrst_data2", if4.data2, 0);
    check("midrst_data1", if4.data1, 0);
    check("midrst_ftick", if4.frame_tick, 0);
    check("midrst_data2_div1", if1.data2, 0);
    @(negedge clk);
    if4.wr_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_div1", if1.data2, 1);
    read_store(got);
    check_store("post_rst_store", got, '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0});

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
